uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver (8 data bits, LSB first, 1 stop bit, no parity by default) at the
//  front of the UART command path. Oversamples the serial line and delivers each
//  byte as rx_data with a one-cycle rx_done strobe. The stopwatch command decoder
//  downstream consumes rx_data/rx_done and interprets bytes such as 'r', 's', 'c', 'm'.
// PARAMETERS
//  CLK_FREQ    100_000_000  system clock frequency, Hz
//  BAUD        9600         line rate, bit/s
//  OVERSAMPLE  16           ticks per bit; must be even and >= 8
// PORTS
//  clk         in   1  system clock
//  rst         in   1  reset, asynchronous, active-high
//  rx          in   1  serial input, asynchronous to clk, idle high
//  rx_data     out  8  last good byte; held until the next good frame
//  rx_done     out  1  one-cycle pulse: new rx_data valid in the same cycle
//  rx_busy     out  1  high while the FSM is outside IDLE
//  frame_err   out  1  one-cycle pulse: stop bit sampled as 0
// BEHAVIOUR
//  - Reset values: rx_data=0, rx_done=0, rx_busy=0, frame_err=0, FSM=IDLE,
//    synchroniser flops=1, all counters=0.
//  - rx passes through a 2-FF synchroniser. All decisions use the synchronised value.
//  - Tick: 1-cycle pulse every DIV = CLK_FREQ/(BAUD*OVERSAMPLE) clocks (integer division).
//    The tick counter runs 0..DIV-1 and is free-running.
//  - The FSM advances only on tick cycles, except the IDLE exit.
//    - IDLE: when synced rx==0, go to START and clear the tick count.
//    - START: after OVERSAMPLE/2 ticks (mid-bit), if rx==0 go to DATA and clear
//      the tick count. Otherwise it is a false start: return to IDLE with no pulses.
//    - DATA: every OVERSAMPLE ticks, sample rx and shift it into bit 7 (right shift,
//      LSB first). After the 8th sample go to STOP.
//    - STOP: after OVERSAMPLE ticks, sample rx.
//      - 1: load rx_data from the shift register and pulse rx_done.
//      - 0: pulse frame_err; rx_data is unchanged.
//      - Either way, return to IDLE in the same cycle, mid stop bit, so that
//        back-to-back frames are accepted.
//  - Latency: rx_done rises about 9.5 bit times plus 3 clk after the start-bit falling edge.
//  - rx_done and frame_err are never both high, and each is high for exactly one clk.
//  - Line held low (break): one frame_err, then IDLE re-triggers and the sequence repeats.
//  - Reset mid-frame: everything returns to reset values immediately. A partial byte
//    is discarded with no pulse.
//  - Widths: bit counter 3b, tick counter $clog2(OVERSAMPLE) bits, divider counter
//    $clog2(DIV) bits.
// CONFIGURATION
//  - UART_RX_PARITY_EN defined: the frame carries an even-parity bit after D7.
//    - A PARITY state samples it after OVERSAMPLE ticks.
//    - Adds output parity_err (1b), a one-cycle pulse.
//    - On parity mismatch: parity_err pulses at the stop-bit sample, rx_done stays 0,
//      and rx_data is unchanged.
//    - If both the stop bit and parity are bad, only frame_err pulses.
//  - UART_RX_PARITY_EN undefined: no PARITY state and no parity_err port (8N1 only).
// STRUCTURE
//  - uart_pkg: FSM state encodings (IDLE, START, DATA, PARITY, STOP), DATA_BITS=8,
//    and the ASCII command constants shared with the command decoder.
//  - Sub-module baud_tick_gen: params CLK_FREQ, BAUD, OVERSAMPLE; ports clk, rst, tick.
//    Instantiated once here and reusable by the UART transmitter.
// TESTING (CLK_FREQ=100 MHz, BAUD=9600: DIV=651, bit = 104,160 ns)
//  1. Send 0x72 'r', 8N1 -> rx_data=0x72, one rx_done pulse, frame_err=0, rx_busy low after.
//  2. Send 'r','s','m' back-to-back, one stop bit each -> three rx_done pulses with
//     rx_data 0x72, 0x73, 0x6D.
//  3. Drive rx low for 3 ticks on an idle line -> no rx_done, no frame_err;
//     rx_busy falls within 9 ticks.
//  4. Send 0x55, then 0x63 with stop bit 0 -> frame_err pulse, no rx_done,
//     rx_data stays 0x55.
//  5. Assert rst during bit 4 of 0xA5 -> outputs at reset values; the following clean
//     0x3C is received correctly.
//  6. UART_RX_PARITY_EN defined: 0x6D with parity bit 0 (wrong) -> parity_err pulse,
//     no rx_done; 0x6D with parity 1 -> rx_done, rx_data=0x6D.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame width and the ASCII
// command bytes that the stopwatch command decoder understands.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic [7:0] CMD_RUN   = 8'h72;  // 'r'
    localparam logic [7:0] CMD_STOP  = 8'h73;  // 's'
    localparam logic [7:0] CMD_CLEAR = 8'h63;  // 'c'
    localparam logic [7:0] CMD_MODE  = 8'h6D;  // 'm'

    // Even parity holds when data plus parity bit carry an even number of ones.
    function automatic logic even_parity_ok(input logic [DATA_BITS-1:0] data,
                                            input logic par_bit);
        return ~(^data ^ par_bit);
    endfunction

endpackage

// File: rtl/uart_rx_baud_tick_gen.sv
// baud_tick_gen: free-running divider producing a one-cycle tick every
// CLK_FREQ/(BAUD*OVERSAMPLE) clocks; shared by the UART receiver and transmitter.
module baud_tick_gen #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Divider next state: wrap at DIV-1 and flag the wrap as a tick.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + CW'(1);
            tick_d = 1'b0;
        end
    end

    // Divider registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 UART receiver with a 2-FF input synchroniser.
// Define UART_RX_PARITY_EN to expect an even-parity bit after D7 (adds parity_err).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_busy,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       frame_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    logic                 tick;
    uart_state_e          state_q, state_d;
    logic                 rx_meta_q, rx_meta_d;
    logic                 rx_sync_q, rx_sync_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_done_q, rx_done_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rx_busy_q, rx_busy_d;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bit_q, parity_bit_d;
    logic                 parity_err_q, parity_err_d;
`endif

    baud_tick_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Receiver next state: synchroniser, tick counting, bit shifting and pulses.
    always_comb begin
        rx_meta_d   = rx;
        rx_sync_d   = rx_meta_q;
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_d = parity_bit_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // Leaving IDLE is not tick-gated so the start edge is caught promptly.
                if (!rx_sync_q) begin
                    state_d    = ST_START;
                    tick_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tick_cnt_q == HALF_LAST) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = 3'd0;
                        if (!rx_sync_q) begin
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d   = '0;
                        parity_bit_d = rx_sync_q;
                        state_d      = ST_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
`endif
            ST_STOP: begin
                // Decide mid stop bit and drop to IDLE so the next start edge is not missed.
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = ST_IDLE;
                        if (rx_sync_q) begin
`ifdef UART_RX_PARITY_EN
                            if (even_parity_ok(shift_q, parity_bit_q)) begin
                                rx_data_d = shift_q;
                                rx_done_d = 1'b1;
                            end else begin
                                parity_err_d = 1'b1;
                            end
`else
                            rx_data_d = shift_q;
                            rx_done_d = 1'b1;
`endif
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tick_cnt_d = '0;
                bit_cnt_d  = 3'd0;
            end
        endcase
        rx_busy_d = (state_d != ST_IDLE);
    end

    // Receiver state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_sync_q    <= rx_sync_d;
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_done_q    <= rx_done_d;
            frame_err_q  <= frame_err_d;
            rx_busy_q    <= rx_busy_d;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= parity_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_done   = rx_done_q;
    assign rx_busy   = rx_busy_q;
    assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random frames, scored
// against an event-level reference model (expected pulses and held byte).
module tb_uart_rx;

    localparam int CLK_FREQ   = 100_000_000;
    localparam int BAUD       = 1_562_500;
    localparam int OVERSAMPLE = 16;
    localparam int DIV        = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int BIT        = DIV * OVERSAMPLE;

    localparam logic [1:0] EV_DONE = 2'd0;
    localparam logic [1:0] EV_FERR = 2'd1;
    localparam logic [1:0] EV_PERR = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;
    logic       perr;

    ev_t        obs_q[$];
    ev_t        exp_q[$];
    logic [7:0] last_good = 8'h00;
    int         n_vec = 0;
    int         n_err = 0;
    logic       prev_pulse = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .rx_busy    (rx_busy),
`ifdef UART_RX_PARITY_EN
        .parity_err (perr),
`endif
        .frame_err  (frame_err)
    );

`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: record every output pulse; pulses must be exclusive and one cycle wide.
    always @(negedge clk) begin
        int   n_pulse;
        ev_t  ev;
        n_pulse = int'(rx_done) + int'(frame_err) + int'(perr);
        if (n_pulse != 0) begin
            check("pulse_excl", 32'(n_pulse), 32'd1);
            check("pulse_width", 32'(prev_pulse), 32'd0);
            if (rx_done)        ev = '{kind: EV_DONE, data: rx_data};
            else if (frame_err) ev = '{kind: EV_FERR, data: 8'h00};
            else                ev = '{kind: EV_PERR, data: 8'h00};
            obs_q.push_back(ev);
        end
        prev_pulse = (n_pulse != 0);
    end

    // Drive one frame and record what a correct receiver must report for it.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(BIT);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ ~par_ok;
        wait_clks(BIT);
`endif
        if (stop_ok) begin
            rx = 1'b1;
            wait_clks(BIT);
            if (par_ok) begin
                exp_q.push_back('{kind: EV_DONE, data: b});
                last_good = b;
            end else begin
                exp_q.push_back('{kind: EV_PERR, data: 8'h00});
            end
        end else begin
            // Release the line before the re-armed start check so it reads as a false start.
            rx = 1'b0;
            wait_clks(BIT - 16);
            rx = 1'b1;
            wait_clks(16 + BIT);
            exp_q.push_back('{kind: EV_FERR, data: 8'h00});
        end
    endtask

    task automatic drain(input string tag);
        wait_clks(2 * BIT);
        check({tag, "_nev"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({tag, "_kind"}, 32'(obs_q[i].kind), 32'(exp_q[i].kind));
            check({tag, "_data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
        end
        check({tag, "_hold"}, 32'(rx_data), 32'(last_good));
        check({tag, "_busy"}, 32'(rx_busy), 32'd0);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        bit         s_ok;
        bit         p_ok;
        int         gap;

        wait_clks(5);
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_done", 32'(rx_done), 32'd0);
        check("rst_busy", 32'(rx_busy), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        rst = 1'b0;
        wait_clks(BIT);

        // 1: single 'r'
        send_frame(8'h72, 1'b1, 1'b1);
        drain("t1");

        // 2: back-to-back 'r','s','m'
        send_frame(8'h72, 1'b1, 1'b1);
        send_frame(8'h73, 1'b1, 1'b1);
        send_frame(8'h6D, 1'b1, 1'b1);
        drain("t2");

        // 3: glitch of 3 ticks is a false start
        rx = 1'b0;
        wait_clks(3 * DIV);
        check("t3_busy_hi", 32'(rx_busy), 32'd1);
        rx = 1'b1;
        wait_clks(9 * DIV + 4 - 3 * DIV);
        check("t3_busy_lo", 32'(rx_busy), 32'd0);
        drain("t3");

        // 4: good 0x55 then 0x63 with a bad stop bit
        send_frame(8'h55, 1'b1, 1'b1);
        send_frame(8'h63, 1'b0, 1'b1);
        drain("t4");

        // 5: reset during bit 4 of 0xA5, then a clean 0x3C
        b  = 8'hA5;
        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            wait_clks(BIT);
        end
        rx = b[4];
        wait_clks(BIT / 2);
        rst = 1'b1;
        wait_clks(3);
        check("t5_rst_data", 32'(rx_data), 32'h00);
        check("t5_rst_busy", 32'(rx_busy), 32'd0);
        check("t5_rst_done", 32'(rx_done), 32'd0);
        check("t5_rst_ferr", 32'(frame_err), 32'd0);
        last_good = 8'h00;
        rx  = 1'b1;
        rst = 1'b0;
        drain("t5a");
        send_frame(8'h3C, 1'b1, 1'b1);
        drain("t5b");

`ifdef UART_RX_PARITY_EN
        // 6: wrong then right parity on 'm'
        send_frame(8'h6D, 1'b1, 1'b0);
        send_frame(8'h6D, 1'b1, 1'b1);
        drain("t6");
`endif

        // Random frames: random bytes, occasional bad stop/parity, random idle gaps.
        for (int n = 0; n < 20; n++) begin
            b    = 8'($urandom_range(0, 255));
            s_ok = ($urandom_range(0, 4) != 0);
            p_ok = 1'b1;
`ifdef UART_RX_PARITY_EN
            p_ok = ($urandom_range(0, 3) != 0);
`endif
            send_frame(b, s_ok, p_ok);
            gap = $urandom_range(0, 2);
            wait_clks(gap * BIT);
        end
        drain("rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
